// File: rtl/cordic_arbiter.sv
// Round-robin arbiter sharing one in-order, fixed-latency CORDIC pipeline among NREQ
// requesters; an in-order tag FIFO routes each result back to its originating requester.
module cordic_arbiter #(
  parameter int NREQ  = 4,
  parameter int DW    = 20,
  parameter int AW    = 20,
  parameter int DEPTH = 32,
  parameter int IDW   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     ch_en,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*DW-1:0]  req_x,
  input  logic [NREQ*DW-1:0]  req_y,
  input  logic [NREQ*AW-1:0]  req_z,
  output logic                cor_dv,
  output logic [DW-1:0]       cor_x,
  output logic [DW-1:0]       cor_y,
  output logic [AW-1:0]       cor_z,
  input  logic                cor_res_dv,
  input  logic [DW-1:0]       cor_res_x,
  input  logic [DW-1:0]       cor_res_y,
  input  logic [AW-1:0]       cor_res_z,
  output logic [NREQ-1:0]     rsp_valid,
  output logic [IDW-1:0]      rsp_id,
  output logic [DW-1:0]       rsp_x,
  output logic [DW-1:0]       rsp_y,
  output logic [AW-1:0]       rsp_z,
  output logic                busy,
  output logic                err_orphan
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
  localparam logic [IDW:0]   NREQ_C  = (IDW + 1)'(NREQ);
  localparam logic [IDW-1:0] LAST_C  = IDW'(NREQ - 1);

  logic [IDW-1:0]  tag_mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] elig;
  logic            gnt;
  logic [IDW-1:0]  gnt_idx;
  logic [DW-1:0]   sel_x;
  logic [DW-1:0]   sel_y;
  logic [AW-1:0]   sel_z;
  logic            pop;
  logic [IDW-1:0]  head;
  logic [NREQ-1:0] head_oh;

  assign elig = req_valid & ch_en;
  assign head = tag_mem[rd_ptr];
  assign pop  = cor_res_dv && (count != '0);

  // Rotating scan from ptr; the occupancy test uses the pre-pop count so a same-cycle
  // pop never frees a slot for this cycle's grant.
  always_comb begin : arb
    logic [IDW:0] j;
    gnt     = 1'b0;
    gnt_idx = '0;
    j       = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = {1'b0, ptr} + (IDW + 1)'(k);
      if (j >= NREQ_C) j = j - NREQ_C;
      if (!gnt && elig[j[IDW-1:0]]) begin
        gnt     = 1'b1;
        gnt_idx = j[IDW-1:0];
      end
    end
    if (rst || (count >= DEPTH_C)) gnt = 1'b0;
  end

  always_comb begin : route
    req_ready = '0;
    head_oh   = '0;
    sel_x     = '0;
    sel_y     = '0;
    sel_z     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_ready[i] = gnt && (gnt_idx == IDW'(i));
      head_oh[i]   = (head == IDW'(i));
      if (gnt_idx == IDW'(i)) begin
        sel_x = req_x[i*DW +: DW];
        sel_y = req_y[i*DW +: DW];
        sel_z = req_z[i*AW +: AW];
      end
    end
  end

  always_comb begin
    count_next = count;
    case ({gnt, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (gnt) tag_mem[wr_ptr] <= gnt_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      cor_dv     <= 1'b0;
      cor_x      <= '0;
      cor_y      <= '0;
      cor_z      <= '0;
      rsp_valid  <= '0;
      rsp_id     <= '0;
      rsp_x      <= '0;
      rsp_y      <= '0;
      rsp_z      <= '0;
      busy       <= 1'b0;
      err_orphan <= 1'b0;
    end else begin
      cor_dv <= gnt;
      if (gnt) begin
        cor_x  <= sel_x;
        cor_y  <= sel_y;
        cor_z  <= sel_z;
        wr_ptr <= wr_ptr + PW'(1);
        ptr    <= (gnt_idx == LAST_C) ? '0 : gnt_idx + IDW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        rsp_id <= head;
        rsp_x  <= cor_res_x;
        rsp_y  <= cor_res_y;
        rsp_z  <= cor_res_z;
      end
      rsp_valid <= pop ? head_oh : '0;
      count     <= count_next;
      busy      <= (count_next != '0);
      if (cor_res_dv && (count == '0)) err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cordic_arbiter.sv
// Scoreboard bench for cordic_arbiter: a round-robin model predicts grants, a delay-line
// stub plays the CORDIC core, and expected responses are queued at grant time.
module tb_cordic_arbiter;
  localparam int NREQ = 4, DW = 20, AW = 20, DEPTH = 32, IDW = 2, LAT = 24;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     ch_en, req_valid, req_ready;
  logic [NREQ*DW-1:0]  req_x, req_y;
  logic [NREQ*AW-1:0]  req_z;
  logic                cor_dv;
  logic [DW-1:0]       cor_x, cor_y;
  logic [AW-1:0]       cor_z;
  logic                cor_res_dv;
  logic [DW-1:0]       cor_res_x, cor_res_y;
  logic [AW-1:0]       cor_res_z;
  logic [NREQ-1:0]     rsp_valid;
  logic [IDW-1:0]      rsp_id;
  logic [DW-1:0]       rsp_x, rsp_y;
  logic [AW-1:0]       rsp_z;
  logic                busy, err_orphan;

  always #5 clk = ~clk;

  cordic_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW), .DEPTH(DEPTH), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .ch_en(ch_en), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_z(req_z),
    .cor_dv(cor_dv), .cor_x(cor_x), .cor_y(cor_y), .cor_z(cor_z),
    .cor_res_dv(cor_res_dv), .cor_res_x(cor_res_x), .cor_res_y(cor_res_y), .cor_res_z(cor_res_z),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_z(rsp_z),
    .busy(busy), .err_orphan(err_orphan)
  );

  typedef struct {
    logic [IDW-1:0] id;
    logic [DW-1:0]  x;
    logic [DW-1:0]  y;
    logic [AW-1:0]  z;
  } rsp_t;

  typedef struct {
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic [AW-1:0] z;
    int            due;
  } stub_t;

  int n_tests = 0, n_fail = 0;
  int cyc = 0;

  logic [IDW-1:0] m_ptr;
  int             m_count;
  logic           m_err, m_cor_dv, m_rv;
  logic [DW-1:0]  m_cx, m_cy;
  logic [AW-1:0]  m_cz;
  rsp_t           m_r;
  rsp_t           exp_q[$];
  stub_t          stub_q[$];
  logic [IDW-1:0] obs_ids[$];

  logic [DW-1:0]  rx[NREQ], ry[NREQ];
  logic [AW-1:0]  rz[NREQ];
  logic           rand_data, hold, release_one, force_res;
  int             gcount[NREQ];
  int             first_hs, first_rsp;
  logic [NREQ-1:0] last_rdy;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic rsp_t core_fn(input int id, input logic [DW-1:0] x, input logic [DW-1:0] y,
                                   input logic [AW-1:0] z);
    rsp_t r;
    r.id = IDW'(id);
    r.x  = ~x;
    r.y  = x ^ y;
    r.z  = z + AW'(5);
    return r;
  endfunction

  task automatic model_reset();
    m_ptr = '0; m_count = 0; m_err = 1'b0; m_cor_dv = 1'b0; m_rv = 1'b0;
    m_cx = '0; m_cy = '0; m_cz = '0;
    m_r = '{id: '0, x: '0, y: '0, z: '0};
    exp_q.delete();
    stub_q.delete();
  endtask

  // One clock cycle: drive core stub and operands, check outputs, advance the model.
  task automatic step();
    stub_t s;
    int g;
    logic pop;
    logic [NREQ-1:0] elig, exp_rdy, exp_rv;
    if (cor_dv === 1'b1) stub_q.push_back('{x: cor_x, y: cor_y, z: cor_z, due: cyc + LAT});
    cor_res_dv = 1'b0;
    if (force_res) begin
      cor_res_dv = 1'b1;
      cor_res_x = DW'($urandom); cor_res_y = DW'($urandom); cor_res_z = AW'($urandom);
    end else if (stub_q.size() > 0 && ((!hold && stub_q[0].due <= cyc) || release_one)) begin
      s = stub_q.pop_front();
      cor_res_dv = 1'b1;
      cor_res_x = ~s.x; cor_res_y = s.x ^ s.y; cor_res_z = s.z + AW'(5);
    end
    if (rand_data)
      for (int i = 0; i < NREQ; i++) begin
        rx[i] = DW'($urandom); ry[i] = DW'($urandom); rz[i] = AW'($urandom);
      end
    for (int i = 0; i < NREQ; i++) begin
      req_x[i*DW +: DW] = rx[i];
      req_y[i*DW +: DW] = ry[i];
      req_z[i*AW +: AW] = rz[i];
    end
    #1;
    elig = req_valid & ch_en;
    g = -1;
    if (!rst && m_count < DEPTH)
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (int'(m_ptr) + k) % NREQ;
        if (g < 0 && elig[j]) g = j;
      end
    exp_rdy = (g >= 0) ? NREQ'(1 << g) : '0;
    exp_rv  = m_rv ? NREQ'(1 << m_r.id) : '0;
    check("req_ready", req_ready, exp_rdy);
    check("cor_dv", cor_dv, m_cor_dv);
    check("cor_x", cor_x, m_cx);
    check("cor_y", cor_y, m_cy);
    check("cor_z", cor_z, m_cz);
    check("rsp_valid", rsp_valid, exp_rv);
    check("rsp_id", rsp_id, m_r.id);
    check("rsp_x", rsp_x, m_r.x);
    check("rsp_y", rsp_y, m_r.y);
    check("rsp_z", rsp_z, m_r.z);
    check("busy", busy, m_count != 0);
    check("err_orphan", err_orphan, m_err);
    last_rdy = req_ready;
    for (int i = 0; i < NREQ; i++) if (req_ready[i] === 1'b1) gcount[i]++;
    if (req_ready[1] === 1'b1 && first_hs < 0) first_hs = cyc;
    if (rsp_valid[1] === 1'b1 && first_rsp < 0) first_rsp = cyc;
    if (rsp_valid !== '0) obs_ids.push_back(rsp_id);
    if (rst) begin
      model_reset();
    end else begin
      pop = cor_res_dv && (m_count > 0);
      if (cor_res_dv && m_count == 0) m_err = 1'b1;
      m_rv = pop;
      if (pop) begin
        if (exp_q.size() > 0) m_r = exp_q.pop_front();
        else check("sb_underflow", 1, 0);
      end
      m_cor_dv = (g >= 0);
      if (g >= 0) begin
        exp_q.push_back(core_fn(g, rx[g], ry[g], rz[g]));
        m_cx = rx[g]; m_cy = ry[g]; m_cz = rz[g];
        m_ptr = IDW'((g + 1) % NREQ);
      end
      m_count = m_count + ((g >= 0) ? 1 : 0) - (pop ? 1 : 0);
    end
    force_res = 1'b0;
    release_one = 1'b0;
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NREQ; i++) gcount[i] = 0;
  endtask

  int total_before, total_after;

  initial begin
    rst = 1'b1; ch_en = '1; req_valid = '0;
    cor_res_dv = 1'b0; cor_res_x = '0; cor_res_y = '0; cor_res_z = '0;
    rand_data = 1'b0; hold = 1'b0; release_one = 1'b0; force_res = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      rx[i] = DW'(i * 111 + 7); ry[i] = DW'(i * 222 + 3); rz[i] = AW'(i * 333 + 1);
    end
    clear_counts();
    first_hs = -1; first_rsp = -1;
    model_reset();
    repeat (2) @(negedge clk);
    run(1);
    rst = 1'b0;

    // Single requester: latency from handshake to response
    rx[1] = DW'(1000); ry[1] = '0; rz[1] = AW'('h20000);
    req_valid = 4'b0010;
    run(40);
    check("latency", first_rsp - first_hs, 26);
    req_valid = '0;
    run(30);

    // Fairness from a fresh pointer
    rst = 1'b1; run(1); rst = 1'b0;
    rand_data = 1'b1; req_valid = '1; clear_counts();
    run(400);
    for (int i = 0; i < NREQ; i++) check($sformatf("fair_cnt%0d", i), gcount[i], 100);

    // Enable mask
    ch_en = 4'b1010; clear_counts();
    run(20);
    check("mask_cnt0", gcount[0], 0);
    check("mask_cnt1", gcount[1], 10);
    check("mask_cnt2", gcount[2], 0);
    check("mask_cnt3", gcount[3], 10);
    ch_en = '1; req_valid = '0;
    run(30);

    // Full FIFO with results withheld, then a single release
    hold = 1'b1; req_valid = '1; clear_counts();
    run(60);
    total_before = gcount[0] + gcount[1] + gcount[2] + gcount[3];
    check("full_grants", total_before, DEPTH);
    release_one = 1'b1;
    run(1);
    check("full_no_same_cycle", last_rdy, 0);
    run(5);
    total_after = gcount[0] + gcount[1] + gcount[2] + gcount[3];
    check("full_release_grants", total_after - total_before, 1);
    req_valid = '0; hold = 1'b0;
    run(70);

    // Routing of interleaved requests 2,0,3
    rand_data = 1'b0;
    rz[2] = AW'('h11111); rz[0] = AW'('h22222); rz[3] = AW'('h33333);
    obs_ids.delete();
    req_valid = 4'b0100; run(1);
    req_valid = 4'b0001; run(1);
    req_valid = 4'b1000; run(1);
    req_valid = '0;
    run(30);
    check("route_n", obs_ids.size(), 3);
    if (obs_ids.size() == 3) begin
      check("route_id0", obs_ids[0], 2);
      check("route_id1", obs_ids[1], 0);
      check("route_id2", obs_ids[2], 3);
    end

    // Orphan result
    force_res = 1'b1;
    run(3);
    check("orphan_flag", err_orphan, 1);

    // Reset mid-traffic; pointer restarts at 0
    rand_data = 1'b1; req_valid = '1;
    run(30);
    rst = 1'b1; run(2); rst = 1'b0;
    run(1);
    check("ptr_restart", last_rdy, 4'b0001);
    req_valid = '0;
    run(30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_arbiter.md
# cordic_arbiter

Round-robin arbiter that shares a single fully pipelined CORDIC datapath (pre-rotation, iteration stages, gain-correcting post stage) among NREQ requesters. Each accepted request is tagged with its requester index in an in-order tag FIFO. Each result returned by the CORDIC core is routed back to the originating requester. The block sits between the per-channel NCO/vectoring clients and the CORDIC top level, and never stalls the CORDIC pipeline.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 20, x/y data width (matches CORDIC DW)
- AW, 20, angle width (matches CORDIC AW)
- DEPTH, 32, tag FIFO depth; power of two, at least the CORDIC end-to-end latency
- IDW, 2, requester index width; equals clog2(NREQ)

Ports (the block uses clk as its clock and rst as a synchronous, active-high reset):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ch_en  in  NREQ  per-requester enable mask; a disabled requester is never granted
- req_valid  in  NREQ  request valid per requester
- req_ready  out  NREQ  request accepted this cycle (one-hot or zero)
- req_x  in  NREQ*DW  flattened x operands; requester i occupies [i*DW +: DW]
- req_y  in  NREQ*DW  flattened y operands, same packing as req_x
- req_z  in  NREQ*AW  flattened angle operands; requester i occupies [i*AW +: AW]
- cor_dv  out  1  issue strobe to the CORDIC core
- cor_x, cor_y  out  DW  operands issued to the CORDIC core
- cor_z  out  AW  angle issued to the CORDIC core
- cor_res_dv  in  1  result strobe from the CORDIC core
- cor_res_x, cor_res_y  in  DW  results from the CORDIC core
- cor_res_z  in  AW  angle result from the CORDIC core
- rsp_valid  out  NREQ  one-hot response strobe
- rsp_id  out  IDW  index of the responding requester
- rsp_x, rsp_y  out  DW  response data, shared by all requesters
- rsp_z  out  AW  response angle, shared by all requesters
- busy  out  1  tag FIFO non-empty, i.e. results still in flight
- err_orphan  out  1  sticky flag; set when a result arrives while the tag FIFO is empty

## Operation
- Eligibility: requester i is eligible when req_valid[i] & ch_en[i].
- Grant condition: a grant is issued only when at least one requester is eligible and count < DEPTH, where count is the tag FIFO occupancy.
- A pop occurring in the same cycle does not free space for that cycle's grant.
- Round-robin arbitration:
  - Pointer ptr holds IDW bits and resets to 0.
  - The granted index is the first eligible index scanning ptr, ptr+1, … modulo NREQ.
  - After a grant to index g, ptr becomes g+1 modulo NREQ. Without a grant, ptr holds.
- req_ready is combinational: one-hot at the granted index, otherwise 0.
- On a grant:
  - The granted x/y/z operands are registered onto cor_x/cor_y/cor_z.
  - cor_dv pulses high for one cycle.
  - The granted index is pushed to the tag FIFO.
- Without a grant, cor_dv is 0 and cor_x/y/z hold their values.
- On cor_res_dv:
  - Pop the head tag h.
  - Next cycle: rsp_valid = one-hot(h), rsp_id = h, and rsp_x/y/z = the registered cor_res data.
- Orphan result: if cor_res_dv arrives with the FIFO empty, nothing is popped, rsp_valid stays 0, and err_orphan sets. err_orphan is cleared only by rst.
- Simultaneous push and pop: count is unchanged, and the FIFO remains correct when full or when empty-with-push.
- Results are strictly in order because the CORDIC core is in-order and fixed-latency. No per-requester backpressure exists: clients must always accept rsp_valid.
- Reset mid-operation: rst clears the FIFO, ptr, count, and err_orphan. Results still in the CORDIC pipeline after reset arrive as orphans. The integrator holds rst on the CORDIC core as well.

## Timing
- Reset values:
  - req_ready 0 while rst is high.
  - cor_dv 0; cor_x/y/z 0.
  - rsp_valid 0, rsp_id 0, rsp_x/y/z 0.
  - busy 0, err_orphan 0.
- Request latency: handshake at cycle T produces cor_dv at T+1.
- Response latency: cor_res_dv at cycle R produces rsp_valid at R+1.
- Issue throughput: one issue per cycle sustained while count < DEPTH.
- busy is registered from count: high from the cycle after the first push until the cycle after the last pop.

## Test plan
- Single requester: requester 1 holds valid with x=1000, y=0, z=0x20000 → req_ready[1] asserts each cycle; cor_dv follows one cycle later with those operands. Model the core as a 24-cycle delay: rsp_valid=4'b0010 and rsp_id=1 arrive 26 cycles after the handshake.
- Fairness: all 4 requesters valid continuously → grant order 0,1,2,3,0,1…; after 400 cycles each requester has exactly 100 grants.
- Enable mask: ch_en=4'b1010 with all requesters valid → only requesters 1 and 3 granted, alternating; requesters 0 and 2 never see req_ready.
- Full FIFO: DEPTH=4 with a core stub that withholds results → exactly 4 grants, then req_ready=0. Release one result → one new grant, issued in the cycle after the pop.
- Routing: interleave requests 2,0,3 with distinct z values → responses return in order with rsp_id 2,0,3 and the matching data. busy drops one cycle after the final pop.
- Orphan and reset: pulse cor_res_dv with the FIFO empty → err_orphan=1 and no rsp_valid. Assert rst mid-traffic → all outputs return to their reset values and ptr restarts at 0.
